// File: rtl/mem_host_ctrl_if.sv
// Host byte-stream bundle for mem_host_ctrl:
// load stream into memory, dump stream out.
interface mem_host_ctrl_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/mem_host_ctrl.sv
// Host-side sequencer: loads data memory, runs the core
// under reset control with a timeout, then dumps results.
module mem_host_ctrl #(
   parameter logic [7:0]  LOAD_BASE  = 8'd0,
   parameter logic [7:0]  DUMP_BASE  = 8'd128,
   parameter logic [7:0]  DUMP_LEN   = 8'd16,
   parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  load_len,
   mem_host_ctrl_if.slave strm,
   output logic        core_reset,
   input  logic        core_done,
   output logic        host_owns_mem,
   output logic        dm_we,
   output logic [7:0]  dm_addr,
   output logic [7:0]  dm_di,
   input  logic [7:0]  dm_dout,
   output logic        busy,
   output logic        timeout,
   output logic [15:0] run_cycles
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CORE_RST,
      ST_RUN,
      ST_DUMP
   } state_t;

   state_t      r_state;
   logic [7:0]  r_len;
   logic [7:0]  r_idx;
   logic [7:0]  r_k;
   logic [15:0] r_run_cycles;
   logic        r_timeout;
   logic        r_first;
   logic        r_core_reset;
   logic        r_host_owns;
   logic        r_busy;
   logic        r_in_ready;
   logic        r_out_valid;

   logic        w_in_fire;
   logic        w_out_fire;
   logic [15:0] w_cyc_nxt;

   assign w_in_fire  = r_in_ready & strm.in_valid;
   assign w_out_fire = r_out_valid & strm.out_ready;
   assign w_cyc_nxt  = (r_run_cycles == 16'hFFFF) ?
                       r_run_cycles : r_run_cycles + 16'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_len        <= 8'd0;
         r_idx        <= 8'd0;
         r_k          <= 8'd0;
         r_run_cycles <= 16'd0;
         r_timeout    <= 1'b0;
         r_first      <= 1'b0;
         r_core_reset <= 1'b1;
         r_host_owns  <= 1'b1;
         r_busy       <= 1'b0;
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_len        <= load_len;
                  r_timeout    <= 1'b0;
                  r_run_cycles <= 16'd0;
                  r_idx        <= 8'd0;
                  r_k          <= 8'd0;
                  r_busy       <= 1'b1;
                  if (load_len != 8'd0) begin
                     r_state    <= ST_LOAD;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state     <= ST_CORE_RST;
                     r_host_owns <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               if (w_in_fire) begin
                  if (r_idx == r_len - 8'd1) begin
                     r_idx       <= 8'd0;
                     r_state     <= ST_CORE_RST;
                     r_in_ready  <= 1'b0;
                     r_host_owns <= 1'b0;
                  end else begin
                     r_idx <= r_idx + 8'd1;
                  end
               end
            end
            ST_CORE_RST: begin
               r_state      <= ST_RUN;
               r_core_reset <= 1'b0;
               r_first      <= 1'b1;
            end
            ST_RUN: begin
               r_first <= 1'b0;
               // done wins over timeout and is not itself counted
               if (core_done && !r_first) begin
                  r_state      <= ST_DUMP;
                  r_core_reset <= 1'b1;
                  r_host_owns  <= 1'b1;
                  r_out_valid  <= 1'b1;
                  r_k          <= 8'd0;
               end else begin
                  r_run_cycles <= w_cyc_nxt;
                  if (w_cyc_nxt >= MAX_CYCLES) begin
                     r_timeout    <= 1'b1;
                     r_state      <= ST_DUMP;
                     r_core_reset <= 1'b1;
                     r_host_owns  <= 1'b1;
                     r_out_valid  <= 1'b1;
                     r_k          <= 8'd0;
                  end
               end
            end
            ST_DUMP: begin
               if (w_out_fire) begin
                  if (r_k == DUMP_LEN - 8'd1) begin
                     r_k         <= 8'd0;
                     r_state     <= ST_IDLE;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                  end else begin
                     r_k <= r_k + 8'd1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign dm_we   = w_in_fire;
   assign dm_addr = (r_state == ST_DUMP) ?
                    DUMP_BASE + r_k : LOAD_BASE + r_idx;
   assign dm_di   = strm.in_data;

   assign strm.in_ready  = r_in_ready;
   assign strm.out_valid = r_out_valid;
   assign strm.out_data  = dm_dout;

   assign core_reset    = r_core_reset;
   assign host_owns_mem = r_host_owns;
   assign busy          = r_busy;
   assign timeout       = r_timeout;
   assign run_cycles    = r_run_cycles;

endmodule

// File: tb/tb_mem_host_ctrl.sv
// Directed bench for mem_host_ctrl with a behavioural
// data memory (unwritten address a reads a ^ 8'h5A).
module tb_mem_host_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  load_len = 8'd0;
   logic        core_reset;
   logic        core_done = 1'b0;
   logic        host_owns_mem;
   logic        dm_we;
   logic [7:0]  dm_addr;
   logic [7:0]  dm_di;
   logic [7:0]  dm_dout;
   logic        busy;
   logic        timeout;
   logic [15:0] run_cycles;

   logic [7:0]   mem [256];
   logic [255:0] wr = '0;

   int n_checks = 0;
   int n_fail = 0;

   mem_host_ctrl_if u_if ();

   mem_host_ctrl #(
      .LOAD_BASE  (8'd254),
      .DUMP_BASE  (8'd254),
      .DUMP_LEN   (8'd4),
      .MAX_CYCLES (16'd20)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .load_len      (load_len),
      .strm          (u_if.slave),
      .core_reset    (core_reset),
      .core_done     (core_done),
      .host_owns_mem (host_owns_mem),
      .dm_we         (dm_we),
      .dm_addr       (dm_addr),
      .dm_di         (dm_di),
      .dm_dout       (dm_dout),
      .busy          (busy),
      .timeout       (timeout),
      .run_cycles    (run_cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dm_we) begin
         mem[dm_addr] <= dm_di;
         wr[dm_addr]  <= 1'b1;
      end
   end

   assign dm_dout = wr[dm_addr] ? mem[dm_addr] : (dm_addr ^ 8'h5A);

   task automatic run_dump(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input logic [3:0] pat);
      logic [7:0] exp_d [4];
      logic [7:0] exp_a;
      int got;
      int cyc;
      exp_d = '{e0, e1, e2, e3};
      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 40) begin
         u_if.out_ready = (cyc < 4) ? pat[cyc] : 1'b1;
         #1;
         exp_a = 8'd254 + 8'(got);
         n_checks++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL dump_valid[%0d] got=%b exp=1", got, u_if.out_valid); end
         n_checks++; if (dm_addr !== exp_a) begin n_fail++; $display("FAIL dump_addr[%0d] got=%h exp=%h", got, dm_addr, exp_a); end
         n_checks++; if (u_if.out_data !== exp_d[got]) begin n_fail++; $display("FAIL dump_data[%0d] cyc%0d got=%h exp=%h", got, cyc, u_if.out_data, exp_d[got]); end
         n_checks++; if (host_owns_mem !== 1'b1 || core_reset !== 1'b1) begin n_fail++; $display("FAIL dump_own got=%b%b exp=11", host_owns_mem, core_reset); end
         if (u_if.out_ready) got++;
         cyc++;
         @(negedge clk);
      end
      u_if.out_ready = 1'b0;
      n_checks++; if (got != 4) begin n_fail++; $display("FAIL dump_count got=%0d exp=4", got); end
      #1;
      n_checks++; if (busy !== 1'b0 || u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL dump_end busy/valid got=%b%b exp=00", busy, u_if.out_valid); end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset got=%b exp=1", core_reset); end
      n_checks++; if (host_owns_mem !== 1'b1) begin n_fail++; $display("FAIL rst_host_owns got=%b exp=1", host_owns_mem); end
      n_checks++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL rst_dm_we got=%b exp=0", dm_we); end
      n_checks++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", u_if.in_ready); end
      n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", u_if.out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
      n_checks++; if (run_cycles !== 16'd0) begin n_fail++; $display("FAIL rst_run_cycles got=%0d exp=0", run_cycles); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_wait busy got=%b exp=0", busy); end
   endtask

   task automatic test_load_run_dump;
      logic [7:0] d [3];
      logic [7:0] a [3];
      d = '{8'hA1, 8'hB2, 8'hC3};
      a = '{8'd254, 8'd255, 8'd0};
      start = 1'b1;
      load_len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         u_if.in_valid = 1'b1;
         u_if.in_data = d[i];
         #1;
         n_checks++; if (u_if.in_ready !== 1'b1 || dm_we !== 1'b1) begin n_fail++; $display("FAIL load_we[%0d] ready/we got=%b%b exp=11", i, u_if.in_ready, dm_we); end
         n_checks++; if (dm_addr !== a[i]) begin n_fail++; $display("FAIL load_addr[%0d] got=%h exp=%h", i, dm_addr, a[i]); end
         n_checks++; if (dm_di !== d[i]) begin n_fail++; $display("FAIL load_di[%0d] got=%h exp=%h", i, dm_di, d[i]); end
         @(negedge clk);
      end
      u_if.in_valid = 1'b0;
      #1;
      n_checks++; if (core_reset !== 1'b1 || host_owns_mem !== 1'b0) begin n_fail++; $display("FAIL crst_state rst/own got=%b%b exp=10", core_reset, host_owns_mem); end
      n_checks++; if (busy !== 1'b1 || dm_we !== 1'b0) begin n_fail++; $display("FAIL crst_busy_we got=%b%b exp=10", busy, dm_we); end
      @(negedge clk);
      core_done = 1'b1;
      #1;
      n_checks++; if (core_reset !== 1'b0 || host_owns_mem !== 1'b0) begin n_fail++; $display("FAIL run_entry rst/own got=%b%b exp=00", core_reset, host_owns_mem); end
      @(negedge clk);
      core_done = 1'b0;
      n_checks++; if (host_owns_mem !== 1'b0) begin n_fail++; $display("FAIL run_first_done_ignored own got=%b exp=0", host_owns_mem); end
      repeat (9) @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      n_checks++; if (host_owns_mem !== 1'b1 || core_reset !== 1'b1) begin n_fail++; $display("FAIL run_exit own/rst got=%b%b exp=11", host_owns_mem, core_reset); end
      n_checks++; if (run_cycles !== 16'd10) begin n_fail++; $display("FAIL run_cycles got=%0d exp=10", run_cycles); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL run_timeout got=%b exp=0", timeout); end
      run_dump(8'hA1, 8'hB2, 8'hC3, 8'h5B, 4'b1111);
      n_checks++; if (run_cycles !== 16'd10) begin n_fail++; $display("FAIL idle_hold_cycles got=%0d exp=10", run_cycles); end
   endtask

   task automatic test_timeout_stall;
      int n;
      start = 1'b1;
      load_len = 8'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      n_checks++; if (core_reset !== 1'b1 || host_owns_mem !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_crst rst/own/busy got=%b%b%b exp=101", core_reset, host_owns_mem, busy); end
      n_checks++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL to_skip_load ready got=%b exp=0", u_if.in_ready); end
      n_checks++; if (run_cycles !== 16'd0) begin n_fail++; $display("FAIL to_clear_cycles got=%0d exp=0", run_cycles); end
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      load_len = 8'd7;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!host_owns_mem && n < 60) begin
         @(negedge clk);
         n++;
      end
      n_checks++; if (host_owns_mem !== 1'b1) begin n_fail++; $display("FAIL to_wait_dump own got=%b exp=1", host_owns_mem); end
      #1;
      n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag got=%b exp=1", timeout); end
      n_checks++; if (run_cycles !== 16'd20) begin n_fail++; $display("FAIL to_cycles got=%0d exp=20", run_cycles); end
      n_checks++; if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL to_start_ignored ready got=%b exp=0", u_if.in_ready); end
      run_dump(8'hA1, 8'hB2, 8'hC3, 8'h5B, 4'b1001);
      repeat (3) @(negedge clk);
      n_checks++; if (timeout !== 1'b1 || run_cycles !== 16'd20) begin n_fail++; $display("FAIL to_idle_hold got=%b/%0d exp=1/20", timeout, run_cycles); end
   endtask

   task automatic test_reset_mid_load;
      logic [7:0] m0;
      logic [7:0] m254;
      logic [7:0] m255;
      start = 1'b1;
      load_len = 8'd5;
      @(negedge clk);
      start = 1'b0;
      u_if.in_valid = 1'b1;
      u_if.in_data = 8'h11;
      @(negedge clk);
      u_if.in_data = 8'h22;
      @(negedge clk);
      u_if.in_data = 8'h33;
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dm_we got=%b exp=0", dm_we); end
      n_checks++; if (core_reset !== 1'b1 || host_owns_mem !== 1'b1) begin n_fail++; $display("FAIL mid_rst rst/own got=%b%b exp=11", core_reset, host_owns_mem); end
      n_checks++; if (busy !== 1'b0 || u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst busy/ready got=%b%b exp=00", busy, u_if.in_ready); end
      @(negedge clk);
      u_if.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      m0 = wr[0] ? mem[0] : 8'h5A;
      m254 = mem[254];
      m255 = mem[255];
      n_checks++; if (m0 !== 8'hC3) begin n_fail++; $display("FAIL mid_rst_no_write mem0 got=%h exp=c3", m0); end
      n_checks++; if (m254 !== 8'h11 || m255 !== 8'h22) begin n_fail++; $display("FAIL mid_rst_partial got=%h,%h exp=11,22", m254, m255); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_wait busy got=%b exp=0", busy); end
      start = 1'b1;
      load_len = 8'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      n_checks++; if (core_reset !== 1'b1 || host_owns_mem !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL post_rst_crst rst/own/busy got=%b%b%b exp=101", core_reset, host_owns_mem, busy); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL post_rst_timeout got=%b exp=0", timeout); end
      @(negedge clk);
      repeat (3) @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      n_checks++; if (host_owns_mem !== 1'b1) begin n_fail++; $display("FAIL post_rst_done own got=%b exp=1", host_owns_mem); end
      n_checks++; if (run_cycles !== 16'd3) begin n_fail++; $display("FAIL post_rst_cycles got=%0d exp=3", run_cycles); end
      run_dump(8'h11, 8'h22, 8'hC3, 8'h5B, 4'b1111);
   endtask

   initial begin
      u_if.in_valid = 1'b0;
      u_if.in_data = 8'h00;
      u_if.out_ready = 1'b0;
      test_reset();
      test_load_run_dump();
      test_timeout_stall();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
